ed_report_tx: RTL

Transmit end of the energy-detection report link. Accepts detection events (energy word plus valid strobe) from the adaptive-threshold detector and buffers them in a small FIFO. Serialises each event as a fixed-format UART frame on a single tx line toward the host-side receiver. Sits between the detector output register and the board UART pin.

---
 rtl/ed_pkg.sv | 37 +++
 rtl/ed_fifo.sv | 51 +++++
 rtl/ed_report_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ed_pkg.sv
// Shared definitions for the energy-detection report transmitter.
// Optional macro: ED_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
package ed_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         UART_BITS = 10;

`ifdef ED_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Byte idx of the frame carrying energy e.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] e);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = e[15:8];
      2'd2:    b = e[7:0];
`ifdef ED_TX_CHECKSUM_EN
      default: b = SYNC_BYTE ^ e[15:8] ^ e[7:0];
`else
      default: b = SYNC_BYTE;
`endif
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ed_fifo.sv
// Small synchronous event FIFO; full/empty/count are registered.
module ed_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;
  logic [AW:0]   cnt_nxt;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign cnt_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign rdata   = mem[rptr];

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/ed_report_tx.sv
// Energy-detection report transmitter: buffers detector events and sends
// each as a UART frame A5, energy[15:8], energy[7:0] (+ checksum when
// ED_TX_CHECKSUM_EN is defined), bytes back-to-back, 8N1, LSB first.
module ed_report_tx
  import ed_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_valid,
  input  logic [DATA_W-1:0] evt_energy,
  output logic              evt_ready,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state, nstate;
  logic [15:0]       cnt, cnt_n;
  logic [2:0]        bit_idx, bit_n;
  logic [1:0]        byte_idx, byte_n;
  logic [7:0]        sh, sh_n;
  logic [15:0]       en_q, en_n;
  logic              tx_n;
  logic              pop, push_ok, bit_end;
  logic              f_full, f_empty;
  logic [CW-1:0]     f_count, cnt_nxt;
  logic [DATA_W-1:0] f_rdata;

  assign push_ok = evt_valid & ~f_full;
  assign cnt_nxt = f_count + CW'(push_ok) - CW'(pop);
  assign bit_end = (cnt == 16'(CLK_DIV - 1));

  ed_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (evt_energy),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // Next-state and serial line; tx is computed one edge ahead so it is a flop.
  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    bit_n  = bit_idx;
    byte_n = byte_idx;
    sh_n   = sh;
    en_n   = en_q;
    tx_n   = tx;
    pop    = 1'b0;
    case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!f_empty) begin
          pop    = 1'b1;
          en_n   = f_rdata;
          sh_n   = SYNC_BYTE;
          byte_n = '0;
          nstate = START;
          tx_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n  = '0;
          bit_n  = '0;
          nstate = DATA;
          tx_n   = sh[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            nstate = STOP;
            tx_n   = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx != 2'(FRAME_BYTES - 1)) begin
            byte_n = byte_idx + 2'd1;
            sh_n   = frame_byte(byte_idx + 2'd1, en_q);
            nstate = START;
            tx_n   = 1'b0;
          end else if (!f_empty) begin
            // Chain straight into the next frame with no idle bit.
            pop    = 1'b1;
            en_n   = f_rdata;
            sh_n   = SYNC_BYTE;
            byte_n = '0;
            nstate = START;
            tx_n   = 1'b0;
          end else begin
            byte_n = '0;
            nstate = IDLE;
            tx_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Serialiser state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      sh        <= '0;
      en_q      <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      evt_ready <= 1'b1;
    end else begin
      state     <= nstate;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      sh        <= sh_n;
      en_q      <= en_n;
      tx        <= tx_n;
      busy      <= (nstate != IDLE);
      overflow  <= overflow | (evt_valid & f_full);
      evt_ready <= (cnt_nxt != CW'(FIFO_DEPTH));
    end
  end

endmodule
